// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types and constants for the stopwatch front-end
//
// Purpose : run-state encoding and debounce timing constants shared by
//           stopwatch_ctrl and its bench.
// Contents: sw_state_t       - FSM state (CLEARED / RUNNING / PAUSED)
//           DB_TICKS_DEFAULT - debounce length for a 100 MHz clock (20 ms)
//           DB_TICKS_SIM     - short debounce length for simulation

package stopwatch_pkg;

   typedef enum logic [1:0] {
      CLEARED = 2'd0,
      RUNNING = 2'd1,
      PAUSED  = 2'd2
   } sw_state_t;

   localparam int DB_TICKS_DEFAULT = 2000000;
   localparam int DB_TICKS_SIM     = 4;

endpackage

// File: rtl/debounce.sv
// rtl/debounce.sv - pushbutton synchronizer, debouncer and press-pulse generator
//
// Purpose : turns one raw asynchronous pushbutton into a single-cycle press
//           pulse on each debounced rising edge.
// Ports   : clk   - system clock, rising edge
//           reset - asynchronous active-low reset
//           btn   - raw button, asynchronous, active-high
//           press - one-cycle pulse when the debounced level rises
// Params  : DB_TICKS - cycles the synced input must differ from the debounced
//                      level before the level follows it (2..2^24)
//           CNT_W    - counter width, 2^CNT_W > DB_TICKS

module debounce #(
   parameter int DB_TICKS = 2000000,
   parameter int CNT_W    = 24
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic press
);

   // The power-up window must outlast the two synchronizer stages so that the
   // level captured at its end reflects the real button, even for tiny DB_TICKS.
   localparam int              INIT_LAST = (DB_TICKS > 3) ? DB_TICKS - 1 : 2;
   localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_TICKS - 1);
   localparam logic [CNT_W-1:0] INIT_END = CNT_W'(INIT_LAST);

   logic             sync_1;
   logic             synced;
   logic             stable;
   logic             armed;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_1 <= 1'b0;
         synced <= 1'b0;
         stable <= 1'b0;
         armed  <= 1'b0;
         cnt    <= '0;
         press  <= 1'b0;
      end else begin
         sync_1 <= btn;
         synced <= sync_1;
         press  <= 1'b0;
         if (!armed) begin
            // Track the button silently after reset so a button held through
            // reset release is adopted as the idle level, not seen as a press.
            stable <= synced;
            if (cnt == INIT_END) begin
               cnt   <= '0;
               armed <= 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else if (synced == stable) begin
            cnt <= '0;
         end else if (cnt == DB_LAST) begin
            stable <= synced;
            cnt    <= '0;
            press  <= synced;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - button front-end and run-state FSM for the stopwatch counter
//
// Purpose : debounces start/stop and clear buttons and drives the counter's
//           go level and clr pulse, plus two status LEDs.
// Ports   : clk       - system clock, rising edge
//           reset     - asynchronous active-low reset
//           btn_start - raw start/stop button, active-high
//           btn_clear - raw clear button, active-high
//           go        - count enable level (RUNNING)
//           clr       - one-cycle pulse, zero the counter
//           running   - status LED, same as go
//           paused    - status LED, PAUSED state

module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int DB_TICKS = DB_TICKS_DEFAULT,
   parameter int CNT_W    = 24
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_start,
   input  logic btn_clear,
   output logic go,
   output logic clr,
   output logic running,
   output logic paused
);

   logic      start_press;
   logic      clear_press;
   sw_state_t state;
   sw_state_t state_nx;
   logic      clr_nx;

   debounce #(.DB_TICKS(DB_TICKS), .CNT_W(CNT_W)) u_db_start (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_start),
      .press (start_press)
   );

   debounce #(.DB_TICKS(DB_TICKS), .CNT_W(CNT_W)) u_db_clear (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_clear),
      .press (clear_press)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= CLEARED;
         go     <= 1'b0;
         paused <= 1'b0;
         clr    <= 1'b0;
      end else begin
         state  <= state_nx;
         go     <= (state_nx == RUNNING);
         paused <= (state_nx == PAUSED);
         clr    <= clr_nx;
      end
   end

   // Clear has priority; a start press arriving in the same cycle is dropped.
   always_comb begin
      state_nx = state;
      clr_nx   = 1'b0;
      if (clear_press) begin
         state_nx = CLEARED;
         clr_nx   = 1'b1;
      end else if (start_press) begin
         case (state)
            CLEARED: state_nx = RUNNING;
            RUNNING: state_nx = PAUSED;
            PAUSED:  state_nx = RUNNING;
            default: state_nx = CLEARED;
         endcase
      end
   end

   assign running = go;

endmodule
